operand_entry: RTL and testbench

- Producer side of the seven-segment display interface: turns the five Basys3 push-buttons into a signed decimal operand (sign, whole 0..99, fraction 0..99).
- Presents the operand on the same field widths the display path consumes: 7-bit whole, 7-bit fraction, 1-bit sign.
- Sits between the board buttons and the calculator core.
- Live edit fields and the cursor feed the display during entry; a committed operand is handed to the core over a valid/ready handshake.

---
 rtl/operand_entry.sv | 233 +++++++++++++++++++++++
 tb/tb_operand_entry.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_entry.sv
// operand_entry
// Turns the five board push-buttons into a signed decimal operand
// (sign, whole 0..99, fraction 0..99) and hands it to the calculator core
// over a valid/ready handshake.
//
// Ports
//   clock_100Mhz     in   system clock
//   reset            in   synchronous, active-high reset
//   btn_up/down/left/right/center  in  raw bouncy buttons (center = commit)
//   operand_ready    in   core accepts the operand this cycle
//   operand_valid    out  committed operand is being offered
//   whole_number     out  committed whole part 0..99
//   fraction_number  out  committed hundredths 0..99
//   sign             out  committed sign, 1 = negative
//   edit_whole       out  live whole value (tens*10 + ones)
//   edit_fraction    out  live fraction value
//   edit_sign        out  live sign
//   cursor           out  0 sign, 1 whole tens, 2 whole ones,
//                         3 fraction tens, 4 fraction ones
module operand_entry #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clock_100Mhz,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    input  logic       operand_ready,
    output logic       operand_valid,
    output logic [6:0] whole_number,
    output logic [6:0] fraction_number,
    output logic       sign,
    output logic [6:0] edit_whole,
    output logic [6:0] edit_fraction,
    output logic       edit_sign,
    output logic [2:0] cursor
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Bit positions inside the button vectors
    localparam int B_RIGHT  = 0;
    localparam int B_LEFT   = 1;
    localparam int B_DOWN   = 2;
    localparam int B_UP     = 3;
    localparam int B_CENTER = 4;

    typedef enum logic [0:0] {
        ST_EDIT = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    logic [4:0]    btn_raw_s;
    logic [4:0]    sync1_r;
    logic [4:0]    sync2_r;
    logic [4:0]    stable_r;
    logic [4:0]    stable_prev_r;
    logic [4:0]    press_r;
    logic [CW-1:0] cnt_r [5];

    state_t     state_r, state_s;
    logic [2:0] cursor_r, cursor_s;
    logic [3:0] wt_r, wt_s, wo_r, wo_s, ft_r, ft_s, fo_r, fo_s;
    logic       esign_r, esign_s;
    logic       valid_r, valid_s;
    logic [6:0] whole_r, whole_s, frac_r, frac_s;
    logic       sign_r, sign_s;
    logic [6:0] edit_whole_r, edit_fraction_r;
    logic [6:0] cur_whole_s, cur_frac_s;

    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] digit_dec(input logic [3:0] d);
        return (d == 4'd0) ? 4'd9 : d - 4'd1;
    endfunction

    function automatic logic [6:0] digits_to_value(input logic [3:0] t, input logic [3:0] o);
        return ({3'd0, t} * 7'd10) + {3'd0, o};
    endfunction

    assign btn_raw_s = {btn_center, btn_up, btn_down, btn_left, btn_right};

    // Synchronise, debounce and edge-detect all five buttons
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            sync1_r       <= 5'd0;
            sync2_r       <= 5'd0;
            stable_r      <= 5'd0;
            stable_prev_r <= 5'd0;
            press_r       <= 5'd0;
            for (int i = 0; i < 5; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            sync1_r       <= btn_raw_s;
            sync2_r       <= sync1_r;
            stable_prev_r <= stable_r;
            // Only a 0->1 move of the accepted level is a press
            press_r       <= stable_r & ~stable_prev_r;
            for (int i = 0; i < 5; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == CNT_MAX) begin
                    stable_r[i] <= ~stable_r[i];
                    cnt_r[i]    <= '0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + 1'b1;
                end
            end
        end
    end

    // Next-state logic: editing, commit and handshake
    always_comb begin
        state_s  = state_r;
        cursor_s = cursor_r;
        wt_s     = wt_r;
        wo_s     = wo_r;
        ft_s     = ft_r;
        fo_s     = fo_r;
        esign_s  = esign_r;
        valid_s  = valid_r;
        whole_s  = whole_r;
        frac_s   = frac_r;
        sign_s   = sign_r;
        // Commit straight from the digits so a digit change one cycle
        // before the commit is not lost behind the edit_* register
        cur_whole_s = digits_to_value(wt_r, wo_r);
        cur_frac_s  = digits_to_value(ft_r, fo_r);
        case (state_r)
            ST_EDIT: begin
                if (press_r[B_CENTER]) begin
                    whole_s = cur_whole_s;
                    frac_s  = cur_frac_s;
                    // No negative zero
                    sign_s  = esign_r & ((cur_whole_s != 7'd0) | (cur_frac_s != 7'd0));
                    valid_s = 1'b1;
                    state_s = ST_HOLD;
                end else if (press_r[B_UP]) begin
                    case (cursor_r)
                        3'd0:    esign_s = ~esign_r;
                        3'd1:    wt_s = digit_inc(wt_r);
                        3'd2:    wo_s = digit_inc(wo_r);
                        3'd3:    ft_s = digit_inc(ft_r);
                        3'd4:    fo_s = digit_inc(fo_r);
                        default: esign_s = esign_r;
                    endcase
                end else if (press_r[B_DOWN]) begin
                    case (cursor_r)
                        3'd0:    esign_s = ~esign_r;
                        3'd1:    wt_s = digit_dec(wt_r);
                        3'd2:    wo_s = digit_dec(wo_r);
                        3'd3:    ft_s = digit_dec(ft_r);
                        3'd4:    fo_s = digit_dec(fo_r);
                        default: esign_s = esign_r;
                    endcase
                end else if (press_r[B_LEFT]) begin
                    cursor_s = (cursor_r == 3'd0) ? 3'd4 : cursor_r - 3'd1;
                end else if (press_r[B_RIGHT]) begin
                    cursor_s = (cursor_r >= 3'd4) ? 3'd0 : cursor_r + 3'd1;
                end else begin
                    state_s = ST_EDIT;
                end
            end
            ST_HOLD: begin
                // Buttons are ignored here; only the core's accept matters
                if (operand_ready) begin
                    valid_s  = 1'b0;
                    wt_s     = 4'd0;
                    wo_s     = 4'd0;
                    ft_s     = 4'd0;
                    fo_s     = 4'd0;
                    esign_s  = 1'b0;
                    cursor_s = 3'd1;
                    state_s  = ST_EDIT;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_EDIT;
            end
        endcase
    end

    // State, edit and committed-operand registers
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state_r         <= ST_EDIT;
            cursor_r        <= 3'd1;
            wt_r            <= 4'd0;
            wo_r            <= 4'd0;
            ft_r            <= 4'd0;
            fo_r            <= 4'd0;
            esign_r         <= 1'b0;
            valid_r         <= 1'b0;
            whole_r         <= 7'd0;
            frac_r          <= 7'd0;
            sign_r          <= 1'b0;
            edit_whole_r    <= 7'd0;
            edit_fraction_r <= 7'd0;
        end else begin
            state_r         <= state_s;
            cursor_r        <= cursor_s;
            wt_r            <= wt_s;
            wo_r            <= wo_s;
            ft_r            <= ft_s;
            fo_r            <= fo_s;
            esign_r         <= esign_s;
            valid_r         <= valid_s;
            whole_r         <= whole_s;
            frac_r          <= frac_s;
            sign_r          <= sign_s;
            edit_whole_r    <= cur_whole_s;
            edit_fraction_r <= cur_frac_s;
        end
    end

    assign operand_valid   = valid_r;
    assign whole_number    = whole_r;
    assign fraction_number = frac_r;
    assign sign            = sign_r;
    assign edit_whole      = edit_whole_r;
    assign edit_fraction   = edit_fraction_r;
    assign edit_sign       = esign_r;
    assign cursor          = cursor_r;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry with a short debounce window. A behavioural
// model tracks cursor, digits and committed operand per button press.
module tb_operand_entry;

    logic       clock_100Mhz = 1'b0;
    logic       reset;
    logic [4:0] btn;             // {center, up, down, left, right}
    logic       operand_ready;
    logic       operand_valid;
    logic [6:0] whole_number;
    logic [6:0] fraction_number;
    logic       sign;
    logic [6:0] edit_whole;
    logic [6:0] edit_fraction;
    logic       edit_sign;
    logic [2:0] cursor;

    localparam logic [4:0] RIGHT  = 5'b00001;
    localparam logic [4:0] LEFT   = 5'b00010;
    localparam logic [4:0] DOWN   = 5'b00100;
    localparam logic [4:0] UP     = 5'b01000;
    localparam logic [4:0] CENTER = 5'b10000;

    int checks = 0;
    int errors = 0;
    int valid_total = 0;

    // Model state
    int m_cursor;
    int m_dig [5];   // 1 whole tens, 2 whole ones, 3 fraction tens, 4 fraction ones
    int m_esign;
    int m_valid;
    int m_whole;
    int m_frac;
    int m_sign;

    operand_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clock_100Mhz    (clock_100Mhz),
        .reset           (reset),
        .btn_up          (btn[3]),
        .btn_down        (btn[2]),
        .btn_left        (btn[1]),
        .btn_right       (btn[0]),
        .btn_center      (btn[4]),
        .operand_ready   (operand_ready),
        .operand_valid   (operand_valid),
        .whole_number    (whole_number),
        .fraction_number (fraction_number),
        .sign            (sign),
        .edit_whole      (edit_whole),
        .edit_fraction   (edit_fraction),
        .edit_sign       (edit_sign),
        .cursor          (cursor)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    // Count every cycle the operand is offered
    always @(posedge clock_100Mhz) begin
        if (operand_valid) valid_total <= valid_total + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock_100Mhz);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cursor = 1;
        for (int i = 0; i < 5; i++) m_dig[i] = 0;
        m_esign = 0;
        m_valid = 0;
        m_whole = 0;
        m_frac  = 0;
        m_sign  = 0;
    endtask

    // Apply one simultaneous group of presses to the model
    task automatic model_event(input logic [4:0] mask);
        int w, f;
        if (m_valid != 0 || mask == 5'd0) return;
        w = m_dig[1] * 10 + m_dig[2];
        f = m_dig[3] * 10 + m_dig[4];
        if (mask[4]) begin
            m_whole = w;
            m_frac  = f;
            m_sign  = (w == 0 && f == 0) ? 0 : m_esign;
            m_valid = 1;
        end else if (mask[3]) begin
            if (m_cursor == 0) m_esign = 1 - m_esign;
            else m_dig[m_cursor] = (m_dig[m_cursor] + 1) % 10;
        end else if (mask[2]) begin
            if (m_cursor == 0) m_esign = 1 - m_esign;
            else m_dig[m_cursor] = (m_dig[m_cursor] + 9) % 10;
        end else if (mask[1]) begin
            m_cursor = (m_cursor + 4) % 5;
        end else begin
            m_cursor = (m_cursor + 1) % 5;
        end
    endtask

    task automatic model_handshake();
        if (m_valid != 0) begin
            m_valid  = 0;
            for (int i = 0; i < 5; i++) m_dig[i] = 0;
            m_esign  = 0;
            m_cursor = 1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cursor"},   int'(cursor),          m_cursor);
        check({tag, ".ewhole"},   int'(edit_whole),      m_dig[1] * 10 + m_dig[2]);
        check({tag, ".efrac"},    int'(edit_fraction),   m_dig[3] * 10 + m_dig[4]);
        check({tag, ".esign"},    int'(edit_sign),       m_esign);
        check({tag, ".valid"},    int'(operand_valid),   m_valid);
        check({tag, ".whole"},    int'(whole_number),    m_whole);
        check({tag, ".frac"},     int'(fraction_number), m_frac);
        check({tag, ".sign"},     int'(sign),            m_sign);
    endtask

    // Hold buttons long enough to pass the debouncer, release, settle
    task automatic press(input logic [4:0] mask);
        btn = mask;
        tick(12);
        btn = 5'd0;
        tick(12);
        model_event(mask);
        if (operand_ready) model_handshake();
    endtask

    task automatic press_n(input logic [4:0] mask, input int n);
        for (int i = 0; i < n; i++) press(mask);
    endtask

    // Accept the held operand and check the one-edge drop
    task automatic handshake(input string tag);
        operand_ready = 1'b1;
        tick(1);
        check({tag, ".drop_valid"},  int'(operand_valid), 0);
        check({tag, ".drop_cursor"}, int'(cursor), 1);
        operand_ready = 1'b0;
        model_handshake();
        tick(2);
        check_all(tag);
    endtask

    initial begin
        int v0;
        int r;
        logic [4:0] mask;
        reset = 1'b1;
        btn = 5'd0;
        operand_ready = 1'b0;
        model_reset();
        tick(3);
        check_all("reset");
        reset = 1'b0;
        tick(2);

        // Glitch shorter than the debounce window is dropped
        btn = UP;
        tick(3);
        btn = 5'd0;
        tick(15);
        check_all("glitch");

        // Long hold gives exactly one increment
        btn = UP;
        tick(20);
        btn = 5'd0;
        tick(12);
        model_event(UP);
        check_all("hold20");
        check("hold20.value", int'(edit_whole), 10);

        // Back to zero, then the 42.75 negative entry
        press(DOWN);
        press_n(UP, 4);
        press(RIGHT); press_n(UP, 2);
        press(RIGHT); press_n(UP, 7);
        press(RIGHT); press_n(UP, 5);
        press_n(LEFT, 4);
        press(UP);
        check_all("entry");
        check("entry.w42", int'(edit_whole), 42);
        check("entry.f75", int'(edit_fraction), 75);

        press(CENTER);
        check_all("commit");
        check("commit.sign_neg", int'(sign), 1);
        tick(10);
        check_all("commit_hold10");
        handshake("hs1");

        // Wrap-around of digits and cursor
        press_n(RIGHT, 3);
        press(DOWN);
        check_all("wrap_fo");
        check("wrap_fo.val", int'(edit_fraction), 9);
        press_n(LEFT, 3);
        press(DOWN);
        press(UP);
        check_all("wrap_wt");
        press_n(RIGHT, 3);
        press(RIGHT);
        check_all("wrap_right");
        press(LEFT);
        check_all("wrap_left");
        press(CENTER);
        handshake("hs2");

        // Negative zero commits as positive
        press(LEFT);
        press(UP);
        check("negzero.esign", int'(edit_sign), 1);
        press(CENTER);
        check_all("negzero");
        handshake("hs3");

        // Center beats up in the same cycle
        press(UP | CENTER);
        check_all("prio");
        handshake("hs4");

        // Buttons during HOLD are discarded
        press(UP);
        press(CENTER);
        press(UP);
        press(LEFT);
        check_all("holdign");
        handshake("hs5");

        // Commit while ready is already high: valid for exactly one cycle
        press(UP);
        v0 = valid_total;
        operand_ready = 1'b1;
        press(CENTER);
        operand_ready = 1'b0;
        check("rdyfirst.cycles", valid_total - v0, 1);
        check_all("rdyfirst");

        // Randomised presses against the model
        for (int k = 0; k < 30; k++) begin
            r = int'($urandom_range(0, 9));
            case (r % 5)
                0: mask = (r == 0) ? CENTER : UP;
                1: mask = UP;
                2: mask = DOWN;
                3: mask = LEFT;
                default: mask = RIGHT;
            endcase
            press(mask);
            check_all("rand");
            if (m_valid != 0) begin
                tick(int'($urandom_range(1, 5)));
                check("rand.held", int'(operand_valid), 1);
                handshake("rand_hs");
            end
        end

        // Reset during HOLD aborts the handshake
        press(UP);
        press(CENTER);
        check("rsthold.pre", int'(operand_valid), 1);
        reset = 1'b1;
        tick(1);
        model_reset();
        check_all("rsthold");
        reset = 1'b0;
        tick(2);
        check_all("rsthold_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
